// File: rtl/tap_pkg.sv
// Shared JTAG TAP definitions: default widths, instruction opcodes, the
// IDCODE value and the TAP controller state names.
package tap_pkg;

  localparam int          IR_W_DEF       = 4;
  localparam int          USER_W_DEF     = 16;
  localparam logic [31:0] IDCODE_VAL_DEF = 32'h1A2B_3C4D;

  localparam logic [IR_W_DEF-1:0] INSTR_BYPASS = 4'b1111;
  localparam logic [IR_W_DEF-1:0] INSTR_IDCODE = 4'b0010;
  localparam logic [IR_W_DEF-1:0] INSTR_USER   = 4'b1000;

  // Low bits loaded into the IR on capture; upper bits are zero.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  typedef enum logic [3:0] {
    TAP_TEST_LOGIC_RESET,
    TAP_RUN_TEST_IDLE,
    TAP_SELECT_DR_SCAN,
    TAP_CAPTURE_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPDATE_DR,
    TAP_SELECT_IR_SCAN,
    TAP_CAPTURE_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPDATE_IR
  } tap_state_e;

endpackage

// File: rtl/tap_ir_dr_jtag_shift_reg.sv
// jtag_shift_reg: generic JTAG capture/shift register, shifted LSB first.
// Ports:
//   tclk_i, rst_n_i        clock and async active-low reset (clears to 0)
//   clear_i                synchronous clear, highest priority
//   capture_i/capture_val_i parallel load
//   shift_i/tdi_i          shift right, tdi enters at the MSB
//   data_o                 register contents (data_o[0] is the serial out)
// The parallel update register, where one exists, lives with its consumer.
module jtag_shift_reg #(
  parameter int W = 8
) (
  input  logic         tclk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic         capture_i,
  input  logic [W-1:0] capture_val_i,
  input  logic         shift_i,
  input  logic         tdi_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i)        data_d = '0;
    else if (capture_i) data_d = capture_val_i;
    else if (shift_i)   data_d = {tdi_i, data_q[W-1:1]};
  end

  always_ff @(posedge tclk_i or negedge rst_n_i) begin
    if (!rst_n_i) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/tap_ir_dr.sv
// tap_ir_dr: JTAG instruction register, data-register bank and TDO driver,
// steered by the one-hot state strobes of the TAP controller.
// Ports:
//   tclk, trst            test clock, async active-low reset
//   tdi                   serial in
//   test_logic_reset, capture_/shift_/update_ ir/dr   TAP state strobes
//   tdo, tdo_en           serial out and enable, launched on falling tclk
//   ir_value              active instruction
//   sel_bypass/sel_idcode decoded DR selects
//   user_capture/user_update/user_update_stb   user DR (TAP_USER_DR_EN only)
// Build option: define TAP_USER_DR_EN to add the user DR and INSTR_USER decode;
// without it INSTR_USER falls through to BYPASS.
module tap_ir_dr #(
  parameter int              IR_W         = tap_pkg::IR_W_DEF,
  parameter logic [31:0]     IDCODE_VAL   = tap_pkg::IDCODE_VAL_DEF,
  parameter logic [IR_W-1:0] INSTR_IDCODE = IR_W'(tap_pkg::INSTR_IDCODE)
`ifdef TAP_USER_DR_EN
  ,
  parameter logic [IR_W-1:0] INSTR_USER   = IR_W'(tap_pkg::INSTR_USER),
  parameter int              USER_W       = tap_pkg::USER_W_DEF
`endif
) (
  input  logic              tclk,
  input  logic              trst,
  input  logic              tdi,
  input  logic              test_logic_reset,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic              capture_ir,
  input  logic              shift_ir,
  input  logic              update_ir,
  output logic              tdo,
  output logic              tdo_en,
  output logic [IR_W-1:0]   ir_value,
  output logic              sel_bypass,
  output logic              sel_idcode
`ifdef TAP_USER_DR_EN
  ,
  input  logic [USER_W-1:0] user_capture,
  output logic [USER_W-1:0] user_update,
  output logic              user_update_stb
`endif
);

  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(tap_pkg::IR_CAPTURE_LSBS);

  // Strobes should be one-hot; if not, reset beats IR beats DR.
  logic ir_any, dr_ok;
  logic ir_cap, ir_sh, ir_upd, dr_cap, dr_sh;
  assign ir_any = capture_ir | shift_ir | update_ir;
  assign ir_cap = ~test_logic_reset & capture_ir;
  assign ir_sh  = ~test_logic_reset & ~capture_ir & shift_ir;
  assign ir_upd = ~test_logic_reset & ~capture_ir & ~shift_ir & update_ir;
  assign dr_ok  = ~test_logic_reset & ~ir_any;
  assign dr_cap = dr_ok & capture_dr;
  assign dr_sh  = dr_ok & ~capture_dr & shift_dr;

  logic [IR_W-1:0] ir_shift;
  logic [IR_W-1:0] ir_value_q, ir_value_d;
  logic [31:0]     id_shift;
  logic            bypass_q, bypass_d;
  logic            sel_user;
  logic            dr_lsb;
  logic            tdo_q, tdo_d, tdo_en_q, tdo_en_d;

  jtag_shift_reg #(.W(IR_W)) u_ir_shift (
    .tclk_i        (tclk),
    .rst_n_i       (trst),
    .clear_i       (test_logic_reset),
    .capture_i     (ir_cap),
    .capture_val_i (IR_CAPTURE),
    .shift_i       (ir_sh),
    .tdi_i         (tdi),
    .data_o        (ir_shift)
  );

  always_comb begin
    ir_value_d = ir_value_q;
    if (test_logic_reset) ir_value_d = INSTR_IDCODE;
    else if (ir_upd)      ir_value_d = ir_shift;
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) ir_value_q <= INSTR_IDCODE;
    else       ir_value_q <= ir_value_d;
  end

  assign ir_value   = ir_value_q;
  assign sel_idcode = (ir_value_q == INSTR_IDCODE);
  assign sel_bypass = ~sel_idcode & ~sel_user;

  jtag_shift_reg #(.W(32)) u_id_shift (
    .tclk_i        (tclk),
    .rst_n_i       (trst),
    .clear_i       (1'b0),
    .capture_i     (dr_cap & sel_idcode),
    .capture_val_i (IDCODE_VAL),
    .shift_i       (dr_sh & sel_idcode),
    .tdi_i         (tdi),
    .data_o        (id_shift)
  );

  always_comb begin
    bypass_d = bypass_q;
    if (dr_cap && sel_bypass)     bypass_d = 1'b0;
    else if (dr_sh && sel_bypass) bypass_d = tdi;
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) bypass_q <= 1'b0;
    else       bypass_q <= bypass_d;
  end

`ifdef TAP_USER_DR_EN
  logic              dr_upd;
  logic [USER_W-1:0] user_shift;
  logic [USER_W-1:0] user_update_q, user_update_d;
  logic              user_stb_q, user_stb_d;

  assign sel_user = (ir_value_q == INSTR_USER);
  assign dr_upd   = dr_ok & ~capture_dr & ~shift_dr & update_dr;

  jtag_shift_reg #(.W(USER_W)) u_user_shift (
    .tclk_i        (tclk),
    .rst_n_i       (trst),
    .clear_i       (1'b0),
    .capture_i     (dr_cap & sel_user),
    .capture_val_i (user_capture),
    .shift_i       (dr_sh & sel_user),
    .tdi_i         (tdi),
    .data_o        (user_shift)
  );

  always_comb begin
    user_update_d = user_update_q;
    user_stb_d    = 1'b0;
    if (dr_upd && sel_user) begin
      user_update_d = user_shift;
      user_stb_d    = 1'b1;
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      user_update_q <= '0;
      user_stb_q    <= 1'b0;
    end else begin
      user_update_q <= user_update_d;
      user_stb_q    <= user_stb_d;
    end
  end

  assign user_update     = user_update_q;
  assign user_update_stb = user_stb_q;

  // Only the serial end of the IDCODE register leaves this block.
  logic unused_id_hi;
  assign unused_id_hi = ^id_shift[31:1];
`else
  assign sel_user = 1'b0;

  // Without the user DR, update_dr has nothing to act on.
  logic unused_sigs;
  assign unused_sigs = ^{update_dr, id_shift[31:1]};
`endif

  always_comb begin
    dr_lsb = bypass_q;
    if (sel_idcode) dr_lsb = id_shift[0];
`ifdef TAP_USER_DR_EN
    if (sel_user)   dr_lsb = user_shift[0];
`endif
  end

  // Launch on the falling edge so each bit is stable half a cycle before the
  // rising edge that samples it downstream.
  always_comb begin
    tdo_en_d = shift_ir | shift_dr;
    tdo_d    = 1'b0;
    if (shift_ir)      tdo_d = ir_shift[0];
    else if (shift_dr) tdo_d = dr_lsb;
  end

  always_ff @(negedge tclk or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo    = tdo_q;
  assign tdo_en = tdo_en_q;

endmodule

// File: tb/tb_tap_ir_dr.sv
module tb_tap_ir_dr;

  logic       tclk = 1'b0;
  logic       trst = 1'b0;
  logic       tdi = 1'b0;
  logic       test_logic_reset = 1'b0;
  logic       capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic       capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
  logic       tdo, tdo_en;
  logic [3:0] ir_value;
  logic       sel_bypass, sel_idcode;
`ifdef TAP_USER_DR_EN
  logic [15:0] user_capture = 16'h0000;
  logic [15:0] user_update;
  logic        user_update_stb;
`endif

  int n_checks  = 0;
  int n_pass    = 0;
  int edge_viol = 0;

  tap_ir_dr dut (
    .tclk             (tclk),
    .trst             (trst),
    .tdi              (tdi),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir),
    .tdo              (tdo),
    .tdo_en           (tdo_en),
    .ir_value         (ir_value),
    .sel_bypass       (sel_bypass),
    .sel_idcode       (sel_idcode)
`ifdef TAP_USER_DR_EN
    ,
    .user_capture     (user_capture),
    .user_update      (user_update),
    .user_update_stb  (user_update_stb)
`endif
  );

  always #5 tclk = ~tclk;

  // tdo/tdo_en may only move on a falling tclk edge (or on async reset).
  always @(tdo or tdo_en) begin
    if (trst === 1'b1 && tclk !== 1'b0) edge_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = din[i];
      @(negedge tclk); #1;
      dout[i] = tdo;
      if (i == 0) check_eq("dr_tdo_en", tdo_en, 1);
      tick();
    end
    shift_dr = 1'b0; tdi = 1'b0;
    update_dr = 1'b1; tick(); update_dr = 1'b0;
  endtask

  task automatic ir_scan(input logic [3:0] din, output logic [3:0] dout);
    dout = '0;
    capture_ir = 1'b1; tick(); capture_ir = 1'b0;
    shift_ir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdi = din[i];
      @(negedge tclk); #1;
      dout[i] = tdo;
      if (i == 0) check_eq("ir_tdo_en", tdo_en, 1);
      tick();
    end
    shift_ir = 1'b0; tdi = 1'b0;
    update_ir = 1'b1; tick(); update_ir = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [3:0]  q;

    repeat (2) @(posedge tclk);
    #1;
    check_eq("rst_ir_value", ir_value, 4'b0010);
    check_eq("rst_sel_idcode", sel_idcode, 1);
    check_eq("rst_sel_bypass", sel_bypass, 0);
    check_eq("rst_tdo", tdo, 0);
    check_eq("rst_tdo_en", tdo_en, 0);
`ifdef TAP_USER_DR_EN
    check_eq("rst_user_update", user_update, 0);
    check_eq("rst_user_stb", user_update_stb, 0);
`endif
    trst = 1'b1;
    tick();

    test_logic_reset = 1'b1; tick(); test_logic_reset = 1'b0;
    check_eq("tlr_ir_value", ir_value, 4'b0010);

    dr_scan(32, 64'h0, d);
    check_eq("idcode_scan", d[31:0], 32'h1A2B_3C4D);
    check_eq("idcode_first_bit", d[0], 1);
    check_eq("idle_tdo_en", tdo_en, 0);

    // Over-length scan: tdi bits emerge after the 32 IDCODE bits.
    dr_scan(36, 64'h5, d);
    check_eq("idcode_wrap", d[35:0], 36'h5_1A2B_3C4D);

    ir_scan(4'b1111, q);
    check_eq("ir_capture_out", q, 4'b0001);
    check_eq("ir_1111_value", ir_value, 4'b1111);
    check_eq("ir_1111_bypass", sel_bypass, 1);
    check_eq("ir_1111_idcode", sel_idcode, 0);

    dr_scan(4, 64'hD, d);
    check_eq("bypass_4", d[3:0], 4'hA);
    dr_scan(8, 64'hC5, d);
    check_eq("bypass_8", d[7:0], 8'h8A);

    ir_scan(4'b0101, q);
    check_eq("ir_0101_capture", q, 4'b0001);
    check_eq("ir_0101_value", ir_value, 4'b0101);
    check_eq("ir_0101_bypass", sel_bypass, 1);
    check_eq("ir_0101_idcode", sel_idcode, 0);

`ifdef TAP_USER_DR_EN
    ir_scan(4'b1000, q);
    check_eq("ir_user_bypass", sel_bypass, 0);
    check_eq("ir_user_idcode", sel_idcode, 0);
    user_capture = 16'hBEEF;
    dr_scan(16, 64'h1234, d);
    check_eq("user_capture_out", d[15:0], 16'hBEEF);
    check_eq("user_update", user_update, 16'h1234);
    check_eq("user_stb_hi", user_update_stb, 1);
    tick();
    check_eq("user_stb_lo", user_update_stb, 0);
`else
    ir_scan(4'b1000, q);
    check_eq("ir_1000_bypass", sel_bypass, 1);
    dr_scan(4, 64'h3, d);
    check_eq("ir_1000_bypass_scan", d[3:0], 4'h6);
`endif

    ir_scan(4'b0010, q);
    check_eq("ir_idcode_sel", sel_idcode, 1);
    dr_scan(32, 64'h0, d);
    check_eq("idcode_rescan", d[31:0], 32'h1A2B_3C4D);

    ir_scan(4'b1111, q);
    test_logic_reset = 1'b1; tick(); test_logic_reset = 1'b0;
    check_eq("tlr_restores_idcode", ir_value, 4'b0010);

    // Async reset during an IDCODE shift: third bit (1) is on tdo first.
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    shift_dr = 1'b1; tdi = 1'b0;
    tick(); tick();
    @(negedge tclk); #1;
    check_eq("pre_rst_tdo", tdo, 1);
    check_eq("pre_rst_tdo_en", tdo_en, 1);
    #2 trst = 1'b0;
    #1;
    check_eq("mid_rst_tdo", tdo, 0);
    check_eq("mid_rst_tdo_en", tdo_en, 0);
    check_eq("mid_rst_ir_value", ir_value, 4'b0010);
`ifdef TAP_USER_DR_EN
    check_eq("mid_rst_user_update", user_update, 0);
`endif
    shift_dr = 1'b0;
    @(posedge tclk); #1;
    trst = 1'b1;
    tick();

    // Async reset during a BYPASS shift returns the IR to IDCODE.
    ir_scan(4'b1111, q);
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    shift_dr = 1'b1; tdi = 1'b1;
    tick();
    @(negedge tclk); #1;
    check_eq("byp_pre_rst_tdo", tdo, 1);
    #2 trst = 1'b0;
    #1;
    check_eq("byp_rst_tdo", tdo, 0);
    check_eq("byp_rst_ir_value", ir_value, 4'b0010);
    check_eq("byp_rst_sel_idcode", sel_idcode, 1);
    shift_dr = 1'b0; tdi = 1'b0;
    @(posedge tclk); #1;
    trst = 1'b1;
    tick();
    dr_scan(32, 64'h0, d);
    check_eq("post_rst_idcode", d[31:0], 32'h1A2B_3C4D);

    check_eq("tdo_edge_only_falling", edge_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
